// File: rtl/uart_rx_fsm.sv
// UART receiver: oversampled start detection with glitch rejection, majority-voted
// mid-bit sampling, 8N1 / 8E1 / 8O1 framing, one-cycle result strobes.
module uart_rx_fsm #(
  parameter int PRESCALE = 8
) (
  input  logic       clck,
  input  logic       rst,
  input  logic       rx_in,
  input  logic       par_en,
  input  logic       par_typ,
  output logic [7:0] p_data,
  output logic       data_valid,
  output logic       par_err,
  output logic       stp_err,
  output logic       busy
);

  localparam int CW = $clog2(PRESCALE);
  localparam logic [CW-1:0] SMP0 = CW'(PRESCALE/2 - 1);
  localparam logic [CW-1:0] SMP1 = CW'(PRESCALE/2);
  localparam logic [CW-1:0] DEC  = CW'(PRESCALE/2 + 1);
  localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t          state, state_d;
  logic [CW-1:0]   edge_cnt, edge_cnt_d;
  logic [2:0]      bit_cnt, bit_cnt_d;
  logic [7:0]      shift, shift_d, p_data_d;
  logic            s0, s1, s0_d, s1_d;
  logic            pen_q, ptyp_q, pen_d, ptyp_d;
  logic            perr_pend, perr_pend_d;
  logic            dv_d, pe_d, se_d;
  logic            maj, at_dec, at_bnd;

  assign busy = (state != IDLE);

  always_comb begin
    maj         = (s0 & s1) | (s0 & rx_in) | (s1 & rx_in);
    at_dec      = (edge_cnt == DEC);
    at_bnd      = (edge_cnt == LAST);
    state_d     = state;
    // PRESCALE is a power of two, so the natural wrap marks the bit boundary
    edge_cnt_d  = edge_cnt + CW'(1);
    bit_cnt_d   = bit_cnt;
    shift_d     = shift;
    s0_d        = (edge_cnt == SMP0) ? rx_in : s0;
    s1_d        = (edge_cnt == SMP1) ? rx_in : s1;
    pen_d       = pen_q;
    ptyp_d      = ptyp_q;
    perr_pend_d = perr_pend;
    p_data_d    = p_data;
    dv_d        = 1'b0;
    pe_d        = 1'b0;
    se_d        = 1'b0;
    case (state)
      IDLE: begin
        edge_cnt_d = '0;
        if (!rx_in) begin
          state_d     = START;
          edge_cnt_d  = CW'(1);
          bit_cnt_d   = 3'd0;
          pen_d       = par_en;
          ptyp_d      = par_typ;
          perr_pend_d = 1'b0;
        end
      end
      START: begin
        if (at_dec && maj) begin
          state_d    = IDLE;
          edge_cnt_d = '0;
        end else if (at_bnd) begin
          state_d = DATA;
        end
      end
      DATA: begin
        if (at_dec) shift_d[bit_cnt] = maj;
        if (at_bnd) begin
          if (bit_cnt == 3'd7) begin
            state_d   = pen_q ? PARITY : STOP;
            bit_cnt_d = 3'd0;
          end else begin
            bit_cnt_d = bit_cnt + 3'd1;
          end
        end
      end
      PARITY: begin
        if (at_dec) perr_pend_d = (maj != (^shift ^ ptyp_q));
        if (at_bnd) state_d = STOP;
      end
      STOP: begin
        // finish at mid-stop so the next start edge is caught with no dead time
        if (at_dec) begin
          se_d       = ~maj;
          pe_d       = perr_pend;
          if (maj && !perr_pend) begin
            dv_d     = 1'b1;
            p_data_d = shift;
          end
          state_d    = IDLE;
          edge_cnt_d = '0;
        end
      end
      default: begin
        state_d    = IDLE;
        edge_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clck) begin
    if (!rst) begin
      state      <= IDLE;
      edge_cnt   <= '0;
      bit_cnt    <= 3'd0;
      shift      <= 8'h00;
      s0         <= 1'b1;
      s1         <= 1'b1;
      pen_q      <= 1'b0;
      ptyp_q     <= 1'b0;
      perr_pend  <= 1'b0;
      p_data     <= 8'h00;
      data_valid <= 1'b0;
      par_err    <= 1'b0;
      stp_err    <= 1'b0;
    end else begin
      state      <= state_d;
      edge_cnt   <= edge_cnt_d;
      bit_cnt    <= bit_cnt_d;
      shift      <= shift_d;
      s0         <= s0_d;
      s1         <= s1_d;
      pen_q      <= pen_d;
      ptyp_q     <= ptyp_d;
      perr_pend  <= perr_pend_d;
      p_data     <= p_data_d;
      data_valid <= dv_d;
      par_err    <= pe_d;
      stp_err    <= se_d;
    end
  end

endmodule

// File: tb/tb_uart_rx_fsm.sv
// Directed bench for uart_rx_fsm at PRESCALE=8: framing, parity, stop error,
// glitch rejection, back-to-back frames and mid-frame reset.
module tb_uart_rx_fsm;
  localparam int P = 8;

  logic       clck = 1'b0;
  logic       rst = 1'b0;
  logic       rx_in = 1'b1;
  logic       par_en = 1'b0;
  logic       par_typ = 1'b0;
  logic [7:0] p_data;
  logic       data_valid, par_err, stp_err, busy;

  int total = 0, bad = 0;
  int cyc = 0, e0 = 0;
  int dv_n = 0, pe_n = 0, se_n = 0, both_n = 0;
  int dv_at = 0, pe_at = 0, se_at = 0;
  int dv0, pe0, se0;

  uart_rx_fsm #(.PRESCALE(P)) dut (
    .clck(clck), .rst(rst), .rx_in(rx_in), .par_en(par_en), .par_typ(par_typ),
    .p_data(p_data), .data_valid(data_valid), .par_err(par_err),
    .stp_err(stp_err), .busy(busy)
  );

  always #5 clck = ~clck;
  always @(posedge clck) cyc <= cyc + 1;

  // strobe monitor; cyc here equals the index of the edge that raised the strobe
  always @(negedge clck) begin
    if (data_valid) begin dv_n++; dv_at = cyc; end
    if (par_err)    begin pe_n++; pe_at = cyc; end
    if (stp_err)    begin se_n++; se_at = cyc; end
    if (data_valid && (par_err || stp_err)) both_n++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clck);
    #1;
  endtask

  task automatic hold(input logic b);
    rx_in = b;
    tick(P);
  endtask

  task automatic mark();
    dv0 = dv_n; pe0 = pe_n; se0 = se_n;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic with_par,
                            input logic pbit, input logic stopb);
    e0 = cyc + 1;
    hold(1'b0);
    for (int i = 0; i < 8; i++) hold(d[i]);
    if (with_par) hold(pbit);
    hold(stopb);
    rx_in = 1'b1;
  endtask

  initial begin
    tick(3);
    chk("rst_pdata", p_data, 8'h00);
    chk("rst_dv", data_valid, 0);
    chk("rst_pe", par_err, 0);
    chk("rst_se", stp_err, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b1;
    tick(3);

    // 8N1 0x55
    mark();
    send_frame(8'h55, 1'b0, 1'b0, 1'b1);
    tick(4);
    chk("f55_dv_n", dv_n - dv0, 1);
    chk("f55_time", dv_at - e0, 77);
    chk("f55_pdata", p_data, 8'h55);
    chk("f55_pe_n", pe_n - pe0, 0);
    chk("f55_se_n", se_n - se0, 0);

    // even parity 0xA3, parity bit 0 is correct; par_en toggled mid-frame is ignored
    par_en = 1'b1; par_typ = 1'b0;
    mark();
    fork
      send_frame(8'hA3, 1'b1, 1'b0, 1'b1);
      begin tick(20); par_en = 1'b0; tick(10); par_en = 1'b1; end
    join
    tick(4);
    chk("fa3e_dv_n", dv_n - dv0, 1);
    chk("fa3e_time", dv_at - e0, 85);
    chk("fa3e_pdata", p_data, 8'hA3);
    chk("fa3e_pe_n", pe_n - pe0, 0);

    // odd parity, same parity bit 0 -> mismatch
    par_typ = 1'b1;
    mark();
    send_frame(8'hA3, 1'b1, 1'b0, 1'b1);
    tick(4);
    chk("fa3o_pe_n", pe_n - pe0, 1);
    chk("fa3o_time", pe_at - e0, 85);
    chk("fa3o_dv_n", dv_n - dv0, 0);
    chk("fa3o_pdata", p_data, 8'hA3);

    // stop bit 0; the low line after it is treated as a start then rejected
    par_en = 1'b0; par_typ = 1'b0;
    mark();
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
    tick(20);
    chk("f3c_se_n", se_n - se0, 1);
    chk("f3c_time", se_at - e0, 77);
    chk("f3c_dv_n", dv_n - dv0, 0);
    chk("f3c_pe_n", pe_n - pe0, 0);
    chk("f3c_pdata", p_data, 8'hA3);
    chk("f3c_idle", busy, 0);

    // two-cycle low glitch
    mark();
    e0 = cyc + 1;
    rx_in = 1'b0;
    tick(2);
    rx_in = 1'b1;
    chk("glt_busy_hi", busy, 1);
    tick(4);
    chk("glt_busy_lo", busy, 0);
    tick(P * 12);
    chk("glt_strobes", (dv_n - dv0) + (pe_n - pe0) + (se_n - se0), 0);

    // back-to-back frames, no gap after a full stop bit
    mark();
    send_frame(8'h12, 1'b0, 1'b0, 1'b1);
    chk("b2b_first", p_data, 8'h12);
    send_frame(8'hEF, 1'b0, 1'b0, 1'b1);
    tick(4);
    chk("b2b_second", p_data, 8'hEF);
    chk("b2b_dv_n", dv_n - dv0, 2);
    chk("b2b_time", dv_at - e0, 77);

    // reset during data bit 4
    mark();
    e0 = cyc + 1;
    hold(1'b0);
    for (int i = 0; i < 4; i++) hold(1'b0);
    rx_in = 1'b1;
    tick(3);
    chk("mrst_busy_pre", busy, 1);
    rst = 1'b0;
    tick(1);
    rst = 1'b1;
    rx_in = 1'b1;
    chk("mrst_pdata", p_data, 8'h00);
    chk("mrst_busy", busy, 0);
    chk("mrst_flags", {29'd0, data_valid, par_err, stp_err}, 0);
    tick(P * 12);
    chk("mrst_strobes", (dv_n - dv0) + (pe_n - pe0) + (se_n - se0), 0);

    mark();
    send_frame(8'h7E, 1'b0, 1'b0, 1'b1);
    tick(4);
    chk("f7e_dv_n", dv_n - dv0, 1);
    chk("f7e_time", dv_at - e0, 77);
    chk("f7e_pdata", p_data, 8'h7E);

    chk("dv_with_err", both_n, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got=running exp=finished");
    $fatal(1);
  end
endmodule
